// File: rtl/hex_cmd_parser_pkg.sv
// ---------------------------------------------------------------------------
// hex_cmd_pkg
// Shared definitions for the hex command parser: FSM state type, the ASCII
// code points the parser cares about, and character-class helpers.
// ---------------------------------------------------------------------------
package hex_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGITS  = 2'd1,
        WAIT_CR = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_Z_UC = 8'h5A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_F_LC = 8'h66;

    // Uppercase command letter A..Z.
    function automatic logic is_letter(input logic [7:0] c);
        return (c >= ASCII_A_UC) && (c <= ASCII_Z_UC);
    endfunction

    // Hex digit: 0..9 or lowercase a..f only. Uppercase A..F are letters.
    function automatic logic is_digit(input logic [7:0] c);
        return ((c >= ASCII_0) && (c <= ASCII_9)) ||
               ((c >= ASCII_A_LC) && (c <= ASCII_F_LC));
    endfunction

endpackage

// File: rtl/hex_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// hex_cmd_parser_if
// Byte-stream input and command-result output bundle of the parser.
//   rx_data/rx_valid : received ASCII byte, one-cycle valid per byte
//   cmd/val          : letter and value of the last good command (held)
//   val_valid        : one-cycle strobe, cmd/val just updated
//   err              : one-cycle strobe, malformed command discarded
//   busy             : command partially received
//   dbg_state        : current parser state, for observation only
// Handshake: rx_valid has no ready; every byte presented with rx_valid=1 is
// consumed in that cycle. Outputs are registered and carry no backpressure.
// master = byte source / result sink, slave = parser.
// ---------------------------------------------------------------------------
interface hex_cmd_parser_if
    import hex_cmd_pkg::*;
#(
    parameter int NDIG = 4
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        cmd;
    logic [4*NDIG-1:0] val;
    logic              val_valid;
    logic              err;
    logic              busy;
    state_t            dbg_state;

    modport master (
        output rx_data, rx_valid,
        input  cmd, val, val_valid, err, busy, dbg_state
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd, val, val_valid, err, busy, dbg_state
    );
endinterface

// File: rtl/hex_cmd_parser_ascii2bin.sv
// ---------------------------------------------------------------------------
// asciiHex2Bin
// Combinational ASCII hex digit to nibble converter.
//   i_ascii : ASCII byte ('0'..'9', 'a'..'f' give correct results)
//   o_nib   : 4-bit binary value
// Bit 6 separates the letter range from the numeral range; letters are
// offset by 9 from their low nibble. Any other input gives a meaningless
// nibble, so callers must qualify the result with their own digit check.
// ---------------------------------------------------------------------------
module asciiHex2Bin (
    input  logic [7:0] i_ascii,
    output logic [3:0] o_nib
);
    logic w_unused_bits;

    assign o_nib         = i_ascii[6] ? (i_ascii[3:0] + 4'd9) : i_ascii[3:0];
    assign w_unused_bits = &{1'b0, i_ascii[7], i_ascii[5:4]};
endmodule

// File: rtl/hex_cmd_parser.sv
// ---------------------------------------------------------------------------
// hex_cmd_parser
// Parses "<LETTER><NDIG lowercase hex digits><CR>" from a byte stream and
// publishes the letter and assembled value with a one-cycle strobe.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hex_cmd_parser_if.slave (byte input, result outputs)
// Malformed commands produce a one-cycle err strobe and are dropped; the
// offending byte is never reused as the start of a new command.
// ---------------------------------------------------------------------------
module hex_cmd_parser
    import hex_cmd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    hex_cmd_parser_if.slave   bus
);
    localparam int VW = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    state_t          r_state;
    logic [7:0]      r_cmd_q;
    logic [VW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_cmd;
    logic [VW-1:0]   r_val;
    logic            r_val_valid;
    logic            r_err;
    logic            r_busy;

    logic [3:0]      w_nib;
    logic [VW-1:0]   w_acc_next;
    logic            w_is_letter;
    logic            w_is_digit;
    logic            w_is_cr;

    asciiHex2Bin u_ascii2bin (
        .i_ascii (bus.rx_data),
        .o_nib   (w_nib)
    );

    assign w_is_letter = is_letter(bus.rx_data);
    assign w_is_digit  = is_digit(bus.rx_data);
    assign w_is_cr     = (bus.rx_data == ASCII_CR);

    // Shift the new nibble in at the bottom; a single-digit accumulator
    // simply takes the nibble.
    generate
        if (NDIG == 1) begin : g_acc_one
            assign w_acc_next = w_nib;
        end else begin : g_acc_many
            assign w_acc_next = {r_acc[VW-5:0], w_nib};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_q     <= 8'h00;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_cmd       <= 8'h00;
            r_val       <= '0;
            r_val_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-asserted below.
            r_val_valid <= 1'b0;
            r_err       <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    IDLE: begin
                        // Non-letters here are line noise and dropped quietly.
                        if (w_is_letter) begin
                            r_cmd_q <= bus.rx_data;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= DIGITS;
                            r_busy  <= 1'b1;
                        end
                    end
                    DIGITS: begin
                        if (w_is_digit) begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CW'(NDIG - 1)) begin
                                r_state <= WAIT_CR;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    WAIT_CR: begin
                        if (w_is_cr) begin
                            r_cmd       <= r_cmd_q;
                            r_val       <= r_acc;
                            r_val_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cmd       = r_cmd;
    assign bus.val       = r_val;
    assign bus.val_valid = r_val_valid;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_hex_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_hex_cmd_parser
// Directed scenarios plus randomized command streams for hex_cmd_parser,
// checked every cycle against a line-buffer reference model.
// ---------------------------------------------------------------------------
module tb_hex_cmd_parser;
    import hex_cmd_pkg::*;

    localparam int NDIG = 4;
    localparam int VW   = 4 * NDIG;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_cmd_parser_if #(.NDIG(NDIG)) bus ();

    hex_cmd_parser #(.NDIG(NDIG)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // line_q holds the bytes of the command currently being received
    // (letter first, then digits); empty means no command in progress.
    logic [7:0]      line_q[$];
    logic [VW+7:0]   exp_q[$];
    logic [7:0]      exp_cmd;
    logic [VW-1:0]   exp_val;
    logic            exp_vv;
    logic            exp_err;

    function automatic int hex_of(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 8'h30;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 8'h61 + 10;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [VW-1:0] v;
        exp_vv  = 1'b0;
        exp_err = 1'b0;
        if (line_q.size() == 0) begin
            if (b >= 8'h41 && b <= 8'h5A) line_q.push_back(b);
        end else if (line_q.size() <= NDIG) begin
            if (hex_of(b) >= 0) begin
                line_q.push_back(b);
            end else begin
                exp_err = 1'b1;
                line_q.delete();
            end
        end else begin
            if (b == 8'h0D) begin
                v = '0;
                for (int i = 1; i <= NDIG; i++) v = v * 16 + VW'(hex_of(line_q[i]));
                exp_cmd = line_q[0];
                exp_val = v;
                exp_vv  = 1'b1;
                exp_q.push_back({exp_cmd, exp_val});
            end else begin
                exp_err = 1'b1;
            end
            line_q.delete();
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        exp_q.delete();
        exp_cmd = 8'h00;
        exp_val = '0;
        exp_vv  = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic check_outputs();
        logic [VW+7:0] e;
        check("val_valid", 32'(bus.val_valid), 32'(exp_vv));
        check("err", 32'(bus.err), 32'(exp_err));
        check("busy", 32'(bus.busy), 32'(line_q.size() != 0));
        check("state_active", 32'(bus.dbg_state != IDLE), 32'(line_q.size() != 0));
        check("cmd", 32'(bus.cmd), 32'(exp_cmd));
        check("val", 32'(bus.val), 32'(exp_val));
        check("strobe_excl", 32'(bus.val_valid & bus.err), 32'd0);
        if (bus.val_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(bus.val_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_cmd_val", 32'({bus.cmd, bus.val}), 32'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: verify the previous cycle's effect, then present a byte.
    task automatic step(input logic [7:0] b, input logic v);
        @(negedge clk);
        check_outputs();
        bus.rx_data  = b;
        bus.rx_valid = v;
        if (v) begin
            model_byte(b);
        end else begin
            exp_vv  = 1'b0;
            exp_err = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'($urandom), 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
    endtask

    task automatic send_cr();
        step(8'h0D, 1'b1);
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #2;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rand_lc_digit();
        int d;
        d = $urandom_range(0, 15);
        return (d < 10) ? 8'(8'h30 + d) : 8'(8'h61 + d - 10);
    endfunction

    task automatic rand_byte(input logic [7:0] b);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        step(b, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_cmd", 32'(bus.cmd), 32'h00);
        check("rst_val", 32'(bus.val), 32'h0);
        check("rst_val_valid", 32'(bus.val_valid), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;

        // Basic good command.
        send_str("L12af"); send_cr(); idle(2);
        // Too few digits.
        send_str("A12"); send_cr(); idle(2);
        // Too many digits, then a good one.
        send_str("T00005"); idle(1);
        send_str("T0001"); send_cr(); idle(1);
        // Uppercase hex rejected, then max value.
        send_str("S1A"); idle(1);
        send_str("Sffff"); send_cr(); idle(1);
        // Noise in idle is ignored.
        send_str("7x"); send_cr(); step(8'h0A, 1'b1); idle(1);
        // Back-to-back commands.
        send_str("A0001"); send_cr(); send_str("B0002"); send_cr(); idle(2);
        // Asynchronous reset mid-command; trailing bytes land in IDLE.
        send_str("L12"); idle(1);
        reset_mid_cycle();
        send_str("34"); send_cr(); idle(2);

        // Randomized command streams with occasional corruption.
        for (int k = 0; k < 300; k++) begin
            int kind;
            int nd;
            int bad_pos;
            kind    = $urandom_range(0, 9);
            nd      = (kind == 0) ? $urandom_range(0, NDIG - 1) :
                      (kind == 1) ? NDIG + 1 : NDIG;
            bad_pos = $urandom_range(0, NDIG - 1);
            if ($urandom_range(0, 3) == 0) rand_byte(8'($urandom));
            rand_byte(8'(8'h41 + $urandom_range(0, 25)));
            for (int j = 0; j < nd; j++) begin
                if (kind == 2 && j == bad_pos)
                    rand_byte(8'(8'h41 + $urandom_range(0, 5)));
                else if (kind == 3 && j == bad_pos)
                    rand_byte(8'($urandom));
                else
                    rand_byte(rand_lc_digit());
            end
            if (kind == 4) rand_byte(8'(8'h41 + $urandom_range(0, 25)));
            else           rand_byte(8'h0D);
        end
        idle(3);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
